ch0re_alu_arb: RTL and testbench

// Shares one ch0re_alu instance between NREQ requesters (e.g. integer issue, branch unit, AGU).

---
 rtl/ch0re_alu_arb_pkg.sv | 30 +++
 rtl/ch0re_alu_intf.sv | 22 ++
 rtl/ch0re_alu.sv | 62 ++++++
 rtl/ch0re_rr_arbiter.sv | 37 +++
 rtl/ch0re_alu_arb.sv | 164 ++++++++++++++++
 tb/tb_ch0re_alu_arb.sv | 335 +++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/ch0re_alu_arb_pkg.sv
// ----------------------------------------------------------------------------
// ch0re_alu_arb_pkg
// Shared types for the ch0re ALU and its requester arbiter.
//   alu_op_e       : ALU operation encoding (ALU_EQ .. ALU_SLTU)
//   alu_arb_req_t  : one captured request {op, s1, s2}; operands are held at
//                    ALU_XLEN_MAX bits so the type is independent of any one
//                    instance's XLEN (instances use the low XLEN bits)
//   alu_op_unsigned: true for ops whose "less" flag is an unsigned compare
// ----------------------------------------------------------------------------
package ch0re_alu_arb_pkg;

  localparam int ALU_XLEN_MAX = 64;

  typedef enum logic [3:0] {
    ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU,
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_e;

  typedef struct packed {
    alu_op_e                 op;
    logic [ALU_XLEN_MAX-1:0] s1;
    logic [ALU_XLEN_MAX-1:0] s2;
  } alu_arb_req_t;

  function automatic logic alu_op_unsigned(input alu_op_e op);
    return (op == ALU_LTU) || (op == ALU_GEU) || (op == ALU_SLTU);
  endfunction

endpackage

// File: rtl/ch0re_alu_intf.sv
// ----------------------------------------------------------------------------
// ch0re_alu_intf
// Connection bundle for the combinational ch0re_alu.
//   op, s1, s2     : operation and operands (driven by the user)
//   res, zero, less: result and flags (driven by the ALU)
// Modports: alu (the ALU side), user (the side issuing operations).
// ----------------------------------------------------------------------------
interface ch0re_alu_intf
  import ch0re_alu_arb_pkg::*;
#(
  parameter int XLEN = 64
);
  alu_op_e           op;
  logic [XLEN-1:0]   s1;
  logic [XLEN-1:0]   s2;
  logic [XLEN-1:0]   res;
  logic              zero;
  logic              less;

  modport alu  (input op, s1, s2, output res, zero, less);
  modport user (output op, s1, s2, input res, zero, less);
endinterface

// File: rtl/ch0re_alu.sv
// ----------------------------------------------------------------------------
// ch0re_alu
// Purely combinational integer ALU.
// Ports (through ch0re_alu_intf.alu bus):
//   bus.op/s1/s2 : operation and operands
//   bus.res      : result; compare ops return 0/1 in bit 0
//   bus.zero     : res == 0
//   bus.less     : s1 < s2, unsigned for LTU/GEU/SLTU, signed otherwise
// ----------------------------------------------------------------------------
module ch0re_alu
  import ch0re_alu_arb_pkg::*;
#(
  parameter int XLEN = 64
)(
  ch0re_alu_intf.alu bus
);

  localparam int SH_W = $clog2(XLEN);

  logic signed [XLEN-1:0] s1_s;
  logic signed [XLEN-1:0] s2_s;
  logic [SH_W-1:0]        shamt;
  logic                   lt_s;
  logic                   lt_u;
  logic [XLEN-1:0]        res;

  function automatic logic [XLEN-1:0] flag_word(input logic b);
    return {{(XLEN-1){1'b0}}, b};
  endfunction

  assign s1_s  = bus.s1;
  assign s2_s  = bus.s2;
  assign shamt = bus.s2[SH_W-1:0];
  assign lt_s  = s1_s < s2_s;
  assign lt_u  = bus.s1 < bus.s2;

  always_comb begin
    res = '0;
    case (bus.op)
      ALU_EQ:            res = flag_word(bus.s1 == bus.s2);
      ALU_NE:            res = flag_word(bus.s1 != bus.s2);
      ALU_LT, ALU_SLT:   res = flag_word(lt_s);
      ALU_GE:            res = flag_word(!lt_s);
      ALU_LTU, ALU_SLTU: res = flag_word(lt_u);
      ALU_GEU:           res = flag_word(!lt_u);
      ALU_ADD:           res = bus.s1 + bus.s2;
      ALU_SUB:           res = bus.s1 - bus.s2;
      ALU_AND:           res = bus.s1 & bus.s2;
      ALU_OR:            res = bus.s1 | bus.s2;
      ALU_XOR:           res = bus.s1 ^ bus.s2;
      ALU_SLL:           res = bus.s1 << shamt;
      ALU_SRL:           res = bus.s1 >> shamt;
      ALU_SRA:           res = s1_s >>> shamt;
      default:           res = '0;
    endcase
  end

  assign bus.res  = res;
  assign bus.zero = (res == '0);
  assign bus.less = alu_op_unsigned(bus.op) ? lt_u : lt_s;

endmodule

// File: rtl/ch0re_rr_arbiter.sv
// ----------------------------------------------------------------------------
// ch0re_rr_arbiter
// Combinational round-robin pick: first requester with req set, scanning
// ptr, ptr+1, ... modulo NREQ.
//   req : request vector
//   ptr : highest-priority index this cycle (caller keeps it < NREQ)
//   gnt : one-hot grant (all zero when nothing requests)
//   idx : index of the granted requester (0 when nothing requests)
// ----------------------------------------------------------------------------
module ch0re_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
)(
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] idx
);

  always_comb begin
    int   k;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(ptr) + i) % NREQ;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/ch0re_alu_arb.sv
// ----------------------------------------------------------------------------
// ch0re_alu_arb
// Shares one ch0re_alu between NREQ requesters. Round-robin grant, two
// register stages (issue reg -> ALU -> response reg), valid/ready handshakes
// on both sides. Accept in cycle N gives o_rsp_valid in cycle N+2; full
// throughput when i_rsp_ready stays high.
// Ports:
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_flush                 drops both stages at the next edge, no accept
//   i_req_valid/o_req_ready per-requester handshake (ready is one-hot)
//   i_req_op/s1/s2          per-requester operation and operands
//   o_rsp_valid/i_rsp_ready response handshake
//   o_rsp_id/res/zero/less  owning requester, ALU result and flags
// Optional build macro CH0RE_ALU_ARB_PERF_EN adds saturating counters:
//   o_perf_grants  accepts per requester
//   o_perf_stalls  cycles with o_rsp_valid & !i_rsp_ready
// ----------------------------------------------------------------------------
module ch0re_alu_arb
  import ch0re_alu_arb_pkg::*;
#(
  parameter  int NREQ = 2,
  parameter  int XLEN = 64,
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
)(
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_flush,
  input  logic [NREQ-1:0]           i_req_valid,
  output logic [NREQ-1:0]           o_req_ready,
  input  alu_op_e [NREQ-1:0]        i_req_op,
  input  logic [NREQ-1:0][XLEN-1:0] i_req_s1,
  input  logic [NREQ-1:0][XLEN-1:0] i_req_s2,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [ID_W-1:0]           o_rsp_id,
  output logic [XLEN-1:0]           o_rsp_res,
  output logic                      o_rsp_zero,
`ifdef CH0RE_ALU_ARB_PERF_EN
  output logic [NREQ-1:0][31:0]     o_perf_grants,
  output logic [31:0]               o_perf_stalls,
`endif
  output logic                      o_rsp_less
);

  logic            issue_adv;
  logic            rsp_adv;
  logic            accept;
  logic [NREQ-1:0] gnt;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] ptr;

  logic            vld_p0;
  alu_arb_req_t    req_p0;
  logic [ID_W-1:0] id_p0;

  logic            vld_p1;
  logic [ID_W-1:0] id_p1;
  logic [XLEN-1:0] res_p1;
  logic            zero_p1;
  logic            less_p1;

  function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] idx);
    return (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
  endfunction

  ch0re_rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_rr (
    .req (i_req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign rsp_adv   = !vld_p1 || i_rsp_ready;
  assign issue_adv = !vld_p0 || rsp_adv;
  // The reset term keeps ready low while reset is held; an empty pipe would
  // otherwise advertise ready to whoever wins arbitration.
  assign o_req_ready = gnt & {NREQ{issue_adv && !i_flush && i_rst_n}};
  assign accept      = |(i_req_valid & o_req_ready);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      ptr    <= '0;
    end else begin
      if (i_flush) begin
        vld_p0 <= 1'b0;
        vld_p1 <= 1'b0;
      end else begin
        if (issue_adv) vld_p0 <= accept;
        if (rsp_adv)   vld_p1 <= vld_p0;
      end
      if (accept) ptr <= ptr_after(gnt_idx);
    end
  end

  // ---- stage p0: issue register ----
  always_ff @(posedge i_clk) begin
    if (accept) begin
      req_p0.op <= i_req_op[gnt_idx];
      req_p0.s1 <= ALU_XLEN_MAX'(i_req_s1[gnt_idx]);
      req_p0.s2 <= ALU_XLEN_MAX'(i_req_s2[gnt_idx]);
      id_p0     <= gnt_idx;
    end
  end

  ch0re_alu_intf #(.XLEN(XLEN)) alu_if ();

  assign alu_if.op = req_p0.op;
  assign alu_if.s1 = req_p0.s1[XLEN-1:0];
  assign alu_if.s2 = req_p0.s2[XLEN-1:0];

  ch0re_alu #(.XLEN(XLEN)) u_alu (.bus(alu_if.alu));

  // ---- stage p1: response register ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      id_p1   <= '0;
      res_p1  <= '0;
      zero_p1 <= 1'b0;
      less_p1 <= 1'b0;
    end else if (vld_p0 && rsp_adv && !i_flush) begin
      id_p1   <= id_p0;
      res_p1  <= alu_if.res;
      zero_p1 <= alu_if.zero;
      less_p1 <= alu_if.less;
    end
  end

  assign o_rsp_valid = vld_p1;
  assign o_rsp_id    = id_p1;
  assign o_rsp_res   = res_p1;
  assign o_rsp_zero  = zero_p1;
  assign o_rsp_less  = less_p1;

`ifdef CH0RE_ALU_ARB_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  logic [NREQ-1:0][31:0] grants_q;
  logic [31:0]           stalls_q;

  // Counters survive i_flush; only reset clears them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grants_q <= '0;
      stalls_q <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (i_req_valid[k] && o_req_ready[k]) grants_q[k] <= sat_inc(grants_q[k]);
      end
      if (vld_p1 && !i_rsp_ready) stalls_q <= sat_inc(stalls_q);
    end
  end

  assign o_perf_grants = grants_q;
  assign o_perf_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_ch0re_alu_arb.sv
// ----------------------------------------------------------------------------
// tb_ch0re_alu_arb
// Directed scenarios followed by randomized traffic for ch0re_alu_arb
// (NREQ=2, XLEN=64). The reference keeps in-flight responses in a queue:
// an entry becomes visible once it has reached the output slot, pops on
// rsp_ready, and grants follow the round-robin rule over the model pointer.
// ----------------------------------------------------------------------------
module tb_ch0re_alu_arb;
  import ch0re_alu_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int XLEN = 64;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      flush;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  alu_op_e [NREQ-1:0]        req_op;
  logic [NREQ-1:0][XLEN-1:0] req_s1;
  logic [NREQ-1:0][XLEN-1:0] req_s2;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [0:0]                rsp_id;
  logic [XLEN-1:0]           rsp_res;
  logic                      rsp_zero;
  logic                      rsp_less;

  always #5 clk = ~clk;

  ch0re_alu_arb #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_flush     (flush),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_op    (req_op),
    .i_req_s1    (req_s1),
    .i_req_s2    (req_s2),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_id    (rsp_id),
    .o_rsp_res   (rsp_res),
    .o_rsp_zero  (rsp_zero),
    .o_rsp_less  (rsp_less)
  );

  typedef struct {
    int          id;
    logic [63:0] res;
    bit          zero;
    bit          less;
    bit          landed;
  } rsp_t;

  rsp_t q[$];
  int   ptr_m;
  int   last_acc;
  int   n_vec = 0;
  int   n_err = 0;
  int   cnt0, cnt1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void ref_alu(input alu_op_e op, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output bit z, output bit l);
    longint sa, sb;
    bit     lts, ltu;
    int     sh;
    sa  = a;
    sb  = b;
    lts = sa < sb;
    ltu = a < b;
    sh  = int'(b[5:0]);
    case (op)
      ALU_EQ:            r = (a == b) ? 64'd1 : 64'd0;
      ALU_NE:            r = (a != b) ? 64'd1 : 64'd0;
      ALU_LT, ALU_SLT:   r = lts ? 64'd1 : 64'd0;
      ALU_GE:            r = lts ? 64'd0 : 64'd1;
      ALU_LTU, ALU_SLTU: r = ltu ? 64'd1 : 64'd0;
      ALU_GEU:           r = ltu ? 64'd0 : 64'd1;
      ALU_ADD:           r = a + b;
      ALU_SUB:           r = a - b;
      ALU_AND:           r = a & b;
      ALU_OR:            r = a | b;
      ALU_XOR:           r = a ^ b;
      ALU_SLL:           r = a << sh;
      ALU_SRL:           r = a >> sh;
      ALU_SRA:           r = 64'(sa >>> sh);
      default:           r = 64'd0;
    endcase
    z = (r == 64'd0);
    l = (op == ALU_LTU || op == ALU_GEU || op == ALU_SLTU) ? ltu : lts;
  endfunction

  function automatic logic [63:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'd1;
      3:       return 64'h8000_0000_0000_0000;
      4:       return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic set_req(input int k, input bit v, input alu_op_e op,
                         input logic [63:0] a, input logic [63:0] b);
    req_valid[k] = v;
    req_op[k]    = op;
    req_s1[k]    = a;
    req_s2[k]    = b;
  endtask

  // Called right after inputs are driven at a falling edge: checks the
  // outputs against the model, advances the model over the next rising
  // edge, and returns at the following falling edge.
  task automatic cycle();
    logic [NREQ-1:0] exp_ready;
    bit              allowed;
    int              g;
    rsp_t            e;
    logic [63:0]     r;
    bit              z, l;
    #1;
    exp_ready = '0;
    g         = -1;
    allowed   = rst_n && !flush && (q.size() < 2 || rsp_ready);
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (ptr_m + i) % NREQ;
      if (g < 0 && req_valid[k]) g = k;
    end
    if (allowed && g >= 0) exp_ready[g] = 1'b1;
    else g = -1;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    if (q.size() > 0 && q[0].landed) begin
      chk("rsp_valid", 64'(rsp_valid), 64'd1);
      chk("rsp_id",    64'(rsp_id),    64'(q[0].id));
      chk("rsp_res",   rsp_res,        q[0].res);
      chk("rsp_zero",  64'(rsp_zero),  64'(q[0].zero));
      chk("rsp_less",  64'(rsp_less),  64'(q[0].less));
    end else begin
      chk("rsp_valid", 64'(rsp_valid), 64'd0);
    end
    last_acc = g;
    if (!rst_n) begin
      q.delete();
      ptr_m = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (q.size() > 0 && q[0].landed && rsp_ready) void'(q.pop_front());
      if (q.size() > 0) begin
        e        = q[0];
        e.landed = 1'b1;
        q[0]     = e;
      end
      if (g >= 0) begin
        ref_alu(req_op[g], req_s1[g], req_s2[g], r, z, l);
        e.id     = g;
        e.res    = r;
        e.zero   = z;
        e.less   = l;
        e.landed = 1'b0;
        q.push_back(e);
        ptr_m = (g + 1) % NREQ;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    ptr_m     = 0;
    last_acc  = -1;
    set_req(0, 1'b1, ALU_ADD, 64'd1, 64'd2);
    set_req(1, 1'b1, ALU_ADD, 64'd3, 64'd4);

    // Reset with every requester asking
    @(negedge clk);
    cycle();
    cycle();
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_id",    64'(rsp_id),    64'd0);
    chk("rst_res",   rsp_res,        64'd0);
    chk("rst_zero",  64'(rsp_zero),  64'd0);
    chk("rst_less",  64'(rsp_less),  64'd0);
    rst_n = 1'b1;
    #1;
    chk("first_gnt", 64'(req_ready), 64'd1);
    cycle();
    req_valid = '0;
    repeat (3) cycle();

    // Single ADD from requester 1
    set_req(1, 1'b1, ALU_ADD, 64'd5, 64'd7);
    cycle();
    req_valid = '0;
    cycle();
    #1;
    chk("single_valid", 64'(rsp_valid), 64'd1);
    chk("single_id",    64'(rsp_id),    64'd1);
    chk("single_res",   rsp_res,        64'd12);
    chk("single_zero",  64'(rsp_zero),  64'd0);
    repeat (2) cycle();

    // Backpressure: SUB 3-3 stuck in the response slot
    rsp_ready = 1'b0;
    set_req(0, 1'b1, ALU_SUB, 64'd3, 64'd3);
    cycle();
    req_valid = '0;
    set_req(1, 1'b1, ALU_ADD, 64'd1, 64'd1);
    cycle();
    set_req(1, 1'b1, ALU_XOR, 64'd5, 64'd6);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_full",  64'(req_ready), 64'd0);
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_res",   rsp_res,        64'd0);
      chk("bp_zero",  64'(rsp_zero),  64'd1);
      cycle();
    end
    rsp_ready = 1'b1;
    cycle();
    req_valid = '0;
    repeat (4) cycle();

    // Signed versus unsigned less
    set_req(0, 1'b1, ALU_LT, '1, 64'd1);
    cycle();
    set_req(0, 1'b1, ALU_LTU, '1, 64'd1);
    cycle();
    #1;
    chk("lt_less", 64'(rsp_less), 64'd1);
    chk("lt_res",  rsp_res,       64'd1);
    req_valid = '0;
    cycle();
    #1;
    chk("ltu_less", 64'(rsp_less), 64'd0);
    chk("ltu_res",  rsp_res,       64'd0);
    repeat (2) cycle();

    // Flush with two ops in flight; pointer must survive
    rsp_ready = 1'b0;
    set_req(0, 1'b1, ALU_ADD, 64'd10, 64'd20);
    cycle();
    set_req(0, 1'b1, ALU_SUB, 64'd9, 64'd4);
    cycle();
    flush = 1'b1;
    set_req(0, 1'b1, ALU_AND, 64'd1, 64'd1);
    cycle();
    flush = 1'b0;
    rsp_ready = 1'b1;
    set_req(1, 1'b1, ALU_OR, 64'd2, 64'd1);
    #1;
    chk("flush_valid", 64'(rsp_valid), 64'd0);
    chk("flush_ptr",   64'(req_ready), 64'd2);
    cycle();
    req_valid = '0;
    repeat (3) cycle();

    // Asynchronous reset with two ops in flight
    rsp_ready = 1'b0;
    set_req(0, 1'b1, ALU_OR, 64'h30, 64'h0f);
    cycle();
    set_req(0, 1'b1, ALU_XOR, 64'hff, 64'h0f);
    cycle();
    req_valid = '0;
    #2;
    rst_n = 1'b0;
    q.delete();
    ptr_m = 0;
    #1;
    chk("arst_valid", 64'(rsp_valid), 64'd0);
    chk("arst_res",   rsp_res,        64'd0);
    cycle();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    set_req(0, 1'b1, ALU_ADD, 64'd1, 64'd1);
    set_req(1, 1'b1, ALU_ADD, 64'd2, 64'd2);
    #1;
    chk("arst_ptr", 64'(req_ready), 64'd1);
    cycle();
    req_valid = '0;
    repeat (3) cycle();

    // Fairness: both always valid
    cnt0 = 0;
    cnt1 = 0;
    set_req(0, 1'b1, ALU_ADD, 64'd100, 64'd1);
    set_req(1, 1'b1, ALU_SUB, 64'd100, 64'd1);
    for (int i = 0; i < 100; i++) begin
      #1;
      if (req_ready[0]) cnt0++;
      if (req_ready[1]) cnt1++;
      cycle();
    end
    chk("fair_cnt0", 64'(cnt0), 64'd50);
    chk("fair_cnt1", 64'(cnt1), 64'd50);
    req_valid = '0;
    repeat (3) cycle();

    // Random traffic; requesters hold until accepted, occasionally drop
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!req_valid[k] || last_acc == k || $urandom_range(0, 15) == 0)
          set_req(k, $urandom_range(0, 2) != 0, alu_op_e'($urandom_range(0, 15)),
                  rnd_opnd(), rnd_opnd());
      end
      rsp_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 39) == 0;
      cycle();
    end
    flush     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
